bitpack_z: RTL and testbench
============================

# bitpack_z

Streams the response vector z (L polynomials × N coefficients, stored mod q in BRAM) into the signature byte stream using BitPack(z, γ1−1, γ1) from FIPS 204 Algorithm 17. Each coefficient becomes the field γ1 − z of COEFF_WIDTH bits, and fields are concatenated LSB-first into DATA_OUT_BITS words. It is the encoding counterpart of the y-mask unpacker: it reads the coefficient BRAM and feeds the signature encoder's word sink over a valid/ready handshake.

## Interface
- L, 7: polynomials in z.
- N, 256: coefficients per polynomial.
- GAMMA1, 19: γ1 = 2^GAMMA1.
- COEFF_WIDTH, GAMMA1+1: packed field width.
- Q, 8380417: modulus.
- DATA_OUT_BITS, 64: output word width. Elaboration assertion: L·N·COEFF_WIDTH % DATA_OUT_BITS == 0.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin packing; sampled only in IDLE.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last word is accepted.
- rd_en_vector_z  out  1  BRAM read enable.
- addr_vector_z  out  $clog2(N·L)  coefficient address, poly-major (r·N + i).
- dout_vector_z  in  24  coefficient mod q, in [0, q); synchronous read, 1-cycle latency.
- pack_data  out  DATA_OUT_BITS  packed word; bit 0 is the earliest field bit.
- pack_valid  out  1  pack_data valid.
- pack_ready  in  1  sink accepts the word.
- pack_last  out  1  high with the final word (index L·N·COEFF_WIDTH/DATA_OUT_BITS − 1).

## Operation
- Field arithmetic: c = dout_vector_z. f = γ1 − c when c ≤ γ1, otherwise γ1 + Q − c. Keep the low COEFF_WIDTH bits.
  - The input precondition is z ∈ [−γ1+1, γ1]. Out-of-range inputs are truncated without any flag.
- Accumulator: acc is DATA_OUT_BITS + COEFF_WIDTH bits wide, with fill count acc_bits. A new field is ORed in at bit position acc_bits.
- Counter coeff_idx runs 0 … L·N.
- IDLE:
  - On start: clear coeff_idx, acc and acc_bits.
  - Set busy and move to READ.
- READ:
  - Assert rd_en_vector_z with addr_vector_z = coeff_idx.
  - Move to LOAD.
- LOAD:
  - Append f(dout_vector_z), add COEFF_WIDTH to acc_bits, increment coeff_idx.
  - If the new acc_bits ≥ DATA_OUT_BITS, move to EMIT. Otherwise move to READ.
- EMIT:
  - pack_valid = 1 and pack_data = acc[DATA_OUT_BITS−1:0].
  - pack_last = 1 when coeff_idx == L·N and acc_bits == DATA_OUT_BITS.
  - On pack_ready: shift acc right by DATA_OUT_BITS and subtract DATA_OUT_BITS from acc_bits. If pack_last, move to DONE; otherwise move to READ.
- DONE: pulse done for one cycle, clear busy, return to IDLE.
- Words cross polynomial boundaries without padding. Residual bits carry over, and no per-poly flush occurs.

## Timing
- Reset values: every output is 0, including addr_vector_z. State is IDLE, acc is 0, acc_bits is 0.
- rst_n assertion at any time, including mid-stream or mid-EMIT, aborts the current operation immediately. done is not pulsed.
- Per-coefficient cost is 2 cycles (READ, LOAD). Each word adds EMIT cycles: ≥1, plus any pack_ready stall cycles.
- First pack_valid: the 9th cycle after the start-sampling edge with default parameters (4 × 2 cycles, then EMIT).
- Full vector with pack_ready tied high: 7·(512 + 80) = 4144 cycles from start to done pulse, ±1 for the IDLE→READ edge.
- Handshake:
  - A transfer occurs on a clock edge where pack_valid && pack_ready.
  - While pack_valid && !pack_ready, pack_data and pack_last hold stable and no BRAM read is issued.
  - pack_valid never drops without a transfer.
- start while busy is ignored. start in the same cycle as the done pulse is ignored.
- pack_ready high outside EMIT has no effect.

## Structure
- Shared package dilithium_pkg holds Q, the GAMMA1 exponent for each parameter set, COEFF_WIDTH derivation, and the word-count localparam L·N·COEFF_WIDTH/DATA_OUT_BITS.
- State enum is local to the module.
- One combinational sub-module, gamma1_sub (c → f, parameterised on Q/GAMMA1/COEFF_WIDTH). It is shared with any later hint/z range checker.

## Test plan
- All z = 0, pack_ready high:
  - 560 words, each field 0x80000. Word 0 = 0x0800008000080000.
  - pack_last only on word 559. done pulses once.
- Single-field corners (z[0][0] set, remaining coefficients in z[0] zero): expected f = pack_data[19:0] of word 0.
  - z[0][0] = 1 → f = 0x7FFFF.
  - z[0][0] = Q−1 → f = 0x80001.
  - z[0][0] = γ1 = 524288 → f = 0x00000.
  - z[0][0] = Q−γ1+1 → f = 0xFFFFF.
- Random z in [−γ1+1, γ1] across all 7 polys, pack_ready high: concatenated stream equals the software BitPack reference. Start-to-done is 4144 ±1 cycles.
- Random pack_ready (50%): identical stream to the test above. pack_data and pack_last stable during stalls. No rd_en_vector_z while stalled in EMIT.
- rst_n pulsed low for 1 cycle mid-poly 3 while pack_valid is high and pack_ready is low:
  - All outputs read 0 during reset.
  - A subsequent start reproduces the full stream from word 0.
- start pulsed again at word 100: ignored. The stream is unchanged, and exactly one done pulse follows word 559.

Source files
------------

// File: rtl/dilithium_pkg.sv
// Shared ML-DSA constants and packing-geometry helpers.
package dilithium_pkg;

    localparam int unsigned DILITHIUM_Q   = 8380417;
    localparam int unsigned GAMMA1_EXP_44 = 17;
    localparam int unsigned GAMMA1_EXP_65 = 19;
    localparam int unsigned GAMMA1_EXP_87 = 19;

    function automatic int unsigned z_coeff_width(input int unsigned gamma1_exp);
        return gamma1_exp + 1;
    endfunction

    function automatic int unsigned z_word_count(input int unsigned l, input int unsigned n,
                                                 input int unsigned coeff_width,
                                                 input int unsigned word_bits);
        return (l * n * coeff_width) / word_bits;
    endfunction

    localparam int unsigned Z_WORDS_87 =
        z_word_count(7, 256, z_coeff_width(GAMMA1_EXP_87), 64);

endpackage

// File: rtl/gamma1_sub.sv
// Maps a coefficient c (mod q) to the packed field gamma1 - z, kept to COEFF_WIDTH bits.
module gamma1_sub #(
    parameter int unsigned Q           = 8380417,
    parameter int unsigned GAMMA1      = 19,
    parameter int unsigned COEFF_WIDTH = GAMMA1 + 1,
    parameter int unsigned C_WIDTH     = 24
) (
    input  logic [C_WIDTH-1:0]     c,
    output logic [COEFF_WIDTH-1:0] f
);

    localparam logic [C_WIDTH-1:0]     G1_C = C_WIDTH'(64'd1 << GAMMA1);
    localparam logic [COEFF_WIDTH-1:0] G1_F = COEFF_WIDTH'(64'd1 << GAMMA1);
    localparam logic [COEFF_WIDTH-1:0] Q_F  = COEFF_WIDTH'(Q);

    logic [COEFF_WIDTH-1:0] c_lo;

    // Only the low field bits survive, so the subtraction runs modulo 2^COEFF_WIDTH.
    always_comb begin
        c_lo = c[COEFF_WIDTH-1:0];
        if (c <= G1_C) begin
            f = G1_F - c_lo;
        end else begin
            f = G1_F + Q_F - c_lo;
        end
    end

endmodule

// File: rtl/bitpack_z.sv
// Packs the response vector z from coefficient BRAM into a valid/ready word stream.
module bitpack_z
    import dilithium_pkg::*;
#(
    parameter int unsigned L             = 7,
    parameter int unsigned N             = 256,
    parameter int unsigned GAMMA1        = GAMMA1_EXP_87,
    parameter int unsigned COEFF_WIDTH   = z_coeff_width(GAMMA1),
    parameter int unsigned Q             = DILITHIUM_Q,
    parameter int unsigned DATA_OUT_BITS = 64,
    parameter int unsigned ADDR_W        = $clog2(N * L)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en_vector_z,
    output logic [ADDR_W-1:0]        addr_vector_z,
    input  logic [23:0]              dout_vector_z,
    output logic [DATA_OUT_BITS-1:0] pack_data,
    output logic                     pack_valid,
    input  logic                     pack_ready,
    output logic                     pack_last
);

    localparam int unsigned NCOEF     = L * N;
    localparam int unsigned IDX_W     = $clog2(NCOEF + 1);
    localparam int unsigned ACC_W     = DATA_OUT_BITS + COEFF_WIDTH;
    localparam int unsigned CNT_W     = $clog2(ACC_W + 1);
    localparam int unsigned NUM_WORDS = z_word_count(L, N, COEFF_WIDTH, DATA_OUT_BITS);

    if (NUM_WORDS * DATA_OUT_BITS != L * N * COEFF_WIDTH) begin : g_bad_geometry
        $error("bitpack_z: L*N*COEFF_WIDTH must be a multiple of DATA_OUT_BITS");
    end

    typedef enum logic [2:0] {StIdle, StRead, StLoad, StEmit, StDone} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   coeff_idx_q, coeff_idx_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   acc_bits_q, acc_bits_d;
    logic [COEFF_WIDTH-1:0] field;
    logic               is_last;

    gamma1_sub #(
        .Q           (Q),
        .GAMMA1      (GAMMA1),
        .COEFF_WIDTH (COEFF_WIDTH),
        .C_WIDTH     (24)
    ) u_gamma1_sub (
        .c (dout_vector_z),
        .f (field)
    );

    assign is_last = (coeff_idx_q == IDX_W'(NCOEF)) && (acc_bits_q == CNT_W'(DATA_OUT_BITS));

    always_comb begin
        state_d        = state_q;
        coeff_idx_d    = coeff_idx_q;
        acc_d          = acc_q;
        acc_bits_d     = acc_bits_q;
        busy           = 1'b0;
        done           = 1'b0;
        rd_en_vector_z = 1'b0;
        addr_vector_z  = '0;
        pack_valid     = 1'b0;
        pack_last      = 1'b0;
        pack_data      = '0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    coeff_idx_d = '0;
                    acc_d       = '0;
                    acc_bits_d  = '0;
                    state_d     = StRead;
                end
            end
            StRead: begin
                busy           = 1'b1;
                rd_en_vector_z = 1'b1;
                addr_vector_z  = ADDR_W'(coeff_idx_q);
                state_d        = StLoad;
            end
            StLoad: begin
                busy        = 1'b1;
                acc_d       = acc_q | (ACC_W'(field) << acc_bits_q);
                acc_bits_d  = acc_bits_q + CNT_W'(COEFF_WIDTH);
                coeff_idx_d = coeff_idx_q + 1'b1;
                state_d     = (acc_bits_d >= CNT_W'(DATA_OUT_BITS)) ? StEmit : StRead;
            end
            StEmit: begin
                busy       = 1'b1;
                pack_valid = 1'b1;
                pack_data  = acc_q[DATA_OUT_BITS-1:0];
                pack_last  = is_last;
                // Residual bits carry into the next word; no per-polynomial flush.
                if (pack_ready) begin
                    acc_d      = acc_q >> DATA_OUT_BITS;
                    acc_bits_d = acc_bits_q - CNT_W'(DATA_OUT_BITS);
                    state_d    = is_last ? StDone : StRead;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            coeff_idx_q <= '0;
            acc_q       <= '0;
            acc_bits_q  <= '0;
        end else begin
            state_q     <= state_d;
            coeff_idx_q <= coeff_idx_d;
            acc_q       <= acc_d;
            acc_bits_q  <= acc_bits_d;
        end
    end

endmodule

// File: tb/tb_bitpack_z.sv
// Directed bench for bitpack_z: zero/corner/random streams, stalls, reset abort, start ignore.
module tb_bitpack_z;

    localparam int NC = 1792;
    localparam int NW = 560;
    localparam int G1 = 524288;
    localparam int QQ = 8380417;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        rd_en_vector_z;
    logic [10:0] addr_vector_z;
    logic [23:0] dout_vector_z;
    logic [63:0] pack_data;
    logic        pack_valid;
    logic        pack_ready;
    logic        pack_last;

    bitpack_z dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .rd_en_vector_z (rd_en_vector_z),
        .addr_vector_z  (addr_vector_z),
        .dout_vector_z  (dout_vector_z),
        .pack_data      (pack_data),
        .pack_valid     (pack_valid),
        .pack_ready     (pack_ready),
        .pack_last      (pack_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [23:0] mem [NC];
    always @(posedge clk) if (rd_en_vector_z) dout_vector_z <= mem[addr_vector_z];

    int          zs [NC];
    logic [63:0] exp_w [NW];
    logic [63:0] got_w [$];
    bit          got_last [$];
    int n_vec, n_fail;
    int done_cnt, done_cyc, first_valid_cyc, stall_err, rd_stall_err, busy_after_done;
    bit aborted;

    // Expected words come straight from signed z: field = gamma1 - z, LSB-first.
    task automatic load_z();
        logic [19:0] f;
        int pos;
        for (int w = 0; w < NW; w++) exp_w[w] = '0;
        for (int k = 0; k < NC; k++) begin
            mem[k] = (zs[k] < 0) ? 24'(zs[k] + QQ) : 24'(zs[k]);
            f = 20'(G1 - zs[k]);
            for (int b = 0; b < 20; b++) begin
                pos = k * 20 + b;
                exp_w[pos / 64][pos % 64] = f[b];
            end
        end
    endtask

    function automatic int count_word_errs();
        int e = 0;
        if (got_w.size() != NW) e++;
        for (int i = 0; i < NW; i++)
            if (i >= got_w.size() || got_w[i] !== exp_w[i]) e++;
        return e;
    endfunction

    function automatic int last_pos();
        int cnt = 0;
        int pos = -1;
        for (int i = 0; i < got_last.size(); i++) if (got_last[i]) begin cnt++; pos = i; end
        return (cnt == 1) ? pos : -1;
    endfunction

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Runs one packing pass; abort_word >= 0 stops while stalled in EMIT after that many words.
    task automatic stream(input bit rnd, input int abort_word, input int restart_word,
                          input bit start_at_done);
        bit          prev_stall = 1'b0;
        logic [63:0] prev_data = '0;
        bit          prev_last = 1'b0;
        bit          restart_sent = 1'b0;
        bit          after_done = 1'b0;
        int          cycles = 0;
        got_w.delete();
        got_last.delete();
        done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
        stall_err = 0; rd_stall_err = 0; busy_after_done = 0; aborted = 1'b0;
        @(posedge clk); #1; start = 1'b1; pack_ready = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        while (cycles < 20000) begin
            cycles++;
            start = 1'b0;
            if (after_done && busy) busy_after_done++;
            if (abort_word >= 0 && got_w.size() >= abort_word && pack_valid) begin
                pack_ready = 1'b0;
                aborted = 1'b1;
                return;
            end
            pack_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (prev_stall && (!pack_valid || pack_data !== prev_data || pack_last !== prev_last))
                stall_err++;
            if (pack_valid && rd_en_vector_z) rd_stall_err++;
            if (pack_valid && first_valid_cyc < 0) first_valid_cyc = cycles;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cycles;
                if (start_at_done) start = 1'b1;
                after_done = 1'b1;
            end
            prev_stall = pack_valid && !pack_ready;
            prev_data  = pack_data;
            prev_last  = pack_last;
            if (pack_valid && pack_ready) begin
                got_w.push_back(pack_data);
                got_last.push_back(pack_last);
            end
            if (restart_word >= 0 && !restart_sent && got_w.size() == restart_word) begin
                start = 1'b1;
                restart_sent = 1'b1;
            end
            if (done_cyc >= 0 && cycles >= done_cyc + 4) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic check_full_stream(input string tag);
        int e;
        int lp;
        e = count_word_errs();
        n_vec++;
        if (e !== 0) begin
            n_fail++;
            $display("FAIL %s_words: got %0d words with %0d bad, want %0d words with 0 bad",
                     tag, got_w.size(), e, NW);
        end
        lp = last_pos();
        n_vec++;
        if (lp !== NW - 1) begin
            n_fail++;
            $display("FAIL %s_last: single pack_last at %0d, want %0d", tag, lp, NW - 1);
        end
        n_vec++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL %s_done: %0d done pulses, want 1", tag, done_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; pack_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({busy, done, rd_en_vector_z, addr_vector_z, pack_valid, pack_last, pack_data} !== '0)
        begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b rd=%b addr=%0d valid=%b last=%b data=%h, want all 0",
                     busy, done, rd_en_vector_z, addr_vector_z, pack_valid, pack_last, pack_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_zero_stream();
        for (int k = 0; k < NC; k++) zs[k] = 0;
        load_z();
        stream(1'b0, -1, -1, 1'b0);
        check_full_stream("zero");
        n_vec++;
        if (got_w.size() == 0 || got_w[0] !== 64'h0800008000080000) begin
            n_fail++;
            $display("FAIL zero_word0: got %h, want 0800008000080000",
                     (got_w.size() > 0) ? got_w[0] : 64'hx);
        end
        n_vec++;
        if (first_valid_cyc !== 9) begin
            n_fail++;
            $display("FAIL first_valid: cycle %0d, want 9", first_valid_cyc);
        end
        n_vec++;
        if (done_cyc < 4143 || done_cyc > 4145) begin
            n_fail++;
            $display("FAIL zero_latency: done at cycle %0d, want 4144 +/- 1", done_cyc);
        end
    endtask

    task automatic test_corners();
        logic [23:0] c_tab [4];
        logic [19:0] f_tab [4];
        logic [63:0] w0;
        c_tab[0] = 24'd1;            f_tab[0] = 20'h7FFFF;
        c_tab[1] = 24'd8380416;      f_tab[1] = 20'h80001;
        c_tab[2] = 24'd524288;       f_tab[2] = 20'h00000;
        c_tab[3] = 24'd7856130;      f_tab[3] = 20'hFFFFF;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < NC; k++) mem[k] = '0;
            mem[0] = c_tab[i];
            stream(1'b0, 1, -1, 1'b0);
            w0 = (got_w.size() > 0) ? got_w[0] : 64'hx;
            n_vec++;
            if (w0[19:0] !== f_tab[i] || w0[39:20] !== 20'h80000) begin
                n_fail++;
                $display("FAIL corner_%0d: c=%0d fields %h/%h, want %h/80000",
                         i, c_tab[i], w0[19:0], w0[39:20], f_tab[i]);
            end
            pulse_reset();
        end
    endtask

    task automatic test_random_stream();
        for (int k = 0; k < NC; k++) zs[k] = int'($urandom_range(0, 2 * G1 - 1)) - (G1 - 1);
        zs[3] = G1;
        zs[7] = -(G1 - 1);
        load_z();
        stream(1'b0, -1, -1, 1'b0);
        check_full_stream("random");
        n_vec++;
        if (done_cyc < 4143 || done_cyc > 4145) begin
            n_fail++;
            $display("FAIL random_latency: done at cycle %0d, want 4144 +/- 1", done_cyc);
        end
    endtask

    task automatic test_random_ready();
        stream(1'b1, -1, -1, 1'b0);
        check_full_stream("stall");
        n_vec++;
        if (stall_err !== 0) begin
            n_fail++;
            $display("FAIL stall_stable: %0d unstable stall cycles, want 0", stall_err);
        end
        n_vec++;
        if (rd_stall_err !== 0) begin
            n_fail++;
            $display("FAIL stall_read: %0d reads during EMIT, want 0", rd_stall_err);
        end
    endtask

    task automatic test_reset_mid();
        stream(1'b0, 250, -1, 1'b0);
        n_vec++;
        if (!aborted || !pack_valid || pack_ready) begin
            n_fail++;
            $display("FAIL abort_point: aborted=%b valid=%b ready=%b, want 1/1/0",
                     aborted, pack_valid, pack_ready);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, rd_en_vector_z, addr_vector_z, pack_valid, pack_last, pack_data} !== '0)
        begin
            n_fail++;
            $display("FAIL midreset_outputs: busy=%b done=%b valid=%b data=%h, want all 0",
                     busy, done, pack_valid, pack_data);
        end
        @(posedge clk); #1;
        n_vec++;
        if (done !== 1'b0 || pack_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_hold: done=%b valid=%b, want 0/0", done, pack_valid);
        end
        rst_n = 1'b1;
        stream(1'b0, -1, -1, 1'b0);
        check_full_stream("restart");
    endtask

    task automatic test_back_to_back();
        stream(1'b0, -1, 100, 1'b1);
        check_full_stream("start_ignore");
        n_vec++;
        if (busy_after_done !== 0) begin
            n_fail++;
            $display("FAIL start_at_done: busy high %0d cycles after done, want 0", busy_after_done);
        end
    endtask

    initial begin
        n_vec = 0;
        n_fail = 0;
        test_reset();
        test_zero_stream();
        test_corners();
        test_random_stream();
        test_random_ready();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
